// File: rtl/uart_pkg.sv
// Shared UART constants and receive-FSM state encoding.
// Used by the RX/TX paths and the FIFO/register wrapper.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS    = 8;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = RX_IDLE,
        ST_START = RX_START,
        ST_DATA  = RX_DATA,
        ST_STOP  = RX_STOP,
        ST_BREAK = RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for asynchronous inputs.
// Resets to 1 so an idle-high line never looks like an edge.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive front-end: start-bit validation, mid-bit
// sampling, stop check and one-cycle hand-off to the RX FIFO.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    input  logic       rx_ready,
    input  logic       clr_overrun,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] TOP_BIT = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    logic                      rx_prev_q;
    rx_state_e                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] rx_data_q;
    logic                      rx_valid_q;
    logic                      frame_err_q;
    logic                      overrun_q;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (rx_pin),
        .q_o  (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_prev_q   <= rx_s;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            // A same-cycle set in STOP overrides this clear
            if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == LAST) begin
                        shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == TOP_BIT) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            if (rx_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer at 16 clocks per bit.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_pin;
    logic       rx_ready;
    logic       clr_overrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ferr_cnt = 0;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } rec_t;
    rec_t got_q[$];

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        bit         ready;
        bit         exp_v;
        bit         exp_fe;
        bit         exp_ov;
    } vec_t;
    vec_t tbl[4];

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_pin     (rx_pin),
        .rx_ready   (rx_ready),
        .clr_overrun(clr_overrun),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back('{rx_data, cyc});
        if (frame_err) ferr_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Start, 8 data bits LSB first, stop; a bad stop leaves the line low
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_pin = bits[i];
            tick(CPB);
        end
    endtask

    task automatic pulse_clr();
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
    endtask

    task automatic expect_byte(input string nm, input int n0,
                               input logic [7:0] d);
        chk({nm, "_cnt"}, got_q.size() - n0, 1);
        if (got_q.size() == n0 + 1) chk({nm, "_data"}, got_q[n0].d, d);
    endtask

    initial begin
        int n0, f0, base, hold, gap;
        bit ovr_m;
        logic [7:0] rd;
        bit rs, rr;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        rx_pin = 1'b1;
        rx_ready = 1'b1;
        clr_overrun = 1'b0;
        #1;
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        tick(2);
        reset = 1'b0;
        tick(5);

        for (int i = 0; i < 4; i++) begin
            pulse_clr();
            tick(3);
            n0 = got_q.size();
            f0 = ferr_cnt;
            rx_ready = tbl[i].ready;
            send_frame(tbl[i].d, tbl[i].stop_ok);
            rx_ready = 1'b1;
            if (!tbl[i].stop_ok) tick(5);
            rx_pin = 1'b1;
            tick(20);
            chk("tbl_vcnt", got_q.size() - n0, int'(tbl[i].exp_v));
            if (tbl[i].exp_v && got_q.size() == n0 + 1)
                chk("tbl_data", got_q[n0].d, tbl[i].d);
            chk("tbl_ferr", ferr_cnt - f0, int'(tbl[i].exp_fe));
            chk("tbl_ovr", overrun, int'(tbl[i].exp_ov));
            chk("tbl_busy", busy, 0);
        end
        pulse_clr();
        tick(5);

        // single frame with latency from the start edge at the pin
        n0 = got_q.size();
        base = cyc;
        send_frame(8'hA5, 1'b1);
        expect_byte("a5", n0, 8'hA5);
        if (got_q.size() == n0 + 1)
            chk_rng("a5_latency", got_q[n0].cyc - base,
                    2 + CPB / 2 + 9 * CPB - 1, 2 + CPB / 2 + 9 * CPB + 1);
        chk("a5_busy", busy, 0);
        chk("a5_ovr", overrun, 0);
        tick(10);

        // back-to-back frames with no idle gap
        n0 = got_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(4);
        chk("b2b_cnt", got_q.size() - n0, 3);
        if (got_q.size() == n0 + 3) begin
            chk("b2b_d0", got_q[n0].d, 8'h00);
            chk("b2b_d1", got_q[n0 + 1].d, 8'hFF);
            chk("b2b_d2", got_q[n0 + 2].d, 8'h3C);
            chk_rng("b2b_gap0", got_q[n0 + 1].cyc - got_q[n0].cyc,
                    10 * CPB - 2, 10 * CPB + 2);
            chk_rng("b2b_gap1", got_q[n0 + 2].cyc - got_q[n0 + 1].cyc,
                    10 * CPB - 2, 10 * CPB + 2);
        end
        tick(10);

        // short low glitch on an idle line
        n0 = got_q.size();
        f0 = ferr_cnt;
        rx_pin = 1'b0;
        tick(5);
        rx_pin = 1'b1;
        chk("glitch_busy_hi", busy, 1);
        tick(9);
        chk("glitch_busy_lo", busy, 0);
        tick(20);
        chk("glitch_vcnt", got_q.size() - n0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);

        // bad stop followed by a held-low line
        n0 = got_q.size();
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        tick(40);
        chk("brk_busy_hi", busy, 1);
        chk("brk_ferr", ferr_cnt - f0, 1);
        chk("brk_vcnt", got_q.size() - n0, 0);
        rx_pin = 1'b1;
        tick(6);
        chk("brk_busy_lo", busy, 0);
        n0 = got_q.size();
        send_frame(8'h12, 1'b1);
        tick(4);
        expect_byte("brk_next", n0, 8'h12);
        tick(10);

        // overrun: set, sticky, cleared, and set winning over clear
        n0 = got_q.size();
        rx_ready = 1'b0;
        send_frame(8'h81, 1'b1);
        rx_ready = 1'b1;
        tick(4);
        chk("ovr_set", overrun, 1);
        chk("ovr_vcnt", got_q.size() - n0, 0);
        chk("ovr_data_held", rx_data, 8'h12);
        tick(30);
        chk("ovr_sticky", overrun, 1);
        pulse_clr();
        chk("ovr_clr", overrun, 0);
        tick(5);
        rx_ready = 1'b0;
        fork
            send_frame(8'h81, 1'b1);
            begin
                tick(2 + CPB / 2 + 9 * CPB);
                clr_overrun = 1'b1;
                tick(1);
                clr_overrun = 1'b0;
            end
        join
        rx_ready = 1'b1;
        tick(2);
        chk("ovr_set_wins", overrun, 1);
        tick(5);

        // asynchronous reset in the middle of the data bits
        n0 = got_q.size();
        fork
            send_frame(8'h7E, 1'b1);
            begin
                tick(60);
                #2;
                reset = 1'b1;
                #1;
                chk("arst_data", rx_data, 0);
                chk("arst_valid", rx_valid, 0);
                chk("arst_ferr", frame_err, 0);
                chk("arst_ovr", overrun, 0);
                chk("arst_busy", busy, 0);
            end
        join
        tick(3);
        reset = 1'b0;
        tick(5);
        chk("arst_no_partial", got_q.size() - n0, 0);
        n0 = got_q.size();
        send_frame(8'h7E, 1'b1);
        tick(4);
        expect_byte("arst_next", n0, 8'h7E);
        tick(5);

        // random frames against a rule-level model
        pulse_clr();
        tick(3);
        ovr_m = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            rr = ($urandom_range(0, 3) != 0);
            n0 = got_q.size();
            f0 = ferr_cnt;
            rx_ready = rr;
            send_frame(rd, rs);
            rx_ready = 1'b1;
            if (!rs) begin
                hold = $urandom_range(0, 30);
                tick(hold);
                rx_pin = 1'b1;
                tick(2 + $urandom_range(0, 5));
            end else begin
                gap = $urandom_range(0, 20);
                tick(gap);
            end
            if (rs && !rr) ovr_m = 1'b1;
            chk("rnd_vcnt", got_q.size() - n0, int'(rs && rr));
            if (rs && rr && got_q.size() == n0 + 1)
                chk("rnd_data", got_q[n0].d, rd);
            chk("rnd_ferr", ferr_cnt - f0, int'(!rs));
            chk("rnd_ovr", overrun, int'(ovr_m));
        end
        tick(20);
        chk("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
